// File: rtl/sd_cic_decim.sv
// sd_cic_decim: third-order CIC (sinc3) decimator.
// Turns the 1-bit sigma-delta bitstream (1 => +1, 0 => -1) back into signed PCM,
// one output sample per 2**LOG2_DECIM enabled input bits.
// Integrators and combs run in W = 3*LOG2_DECIM+2 bit two's complement; the
// integrators are allowed to wrap because the comb differences stay exact mod 2**W.
module sd_cic_decim #(
  parameter int LOG2_DECIM = 6,
  parameter int OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_en,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid,
  output logic             pcm_sat
);

  // Internal arithmetic width and output scaling
  localparam int W     = 3*LOG2_DECIM + 2;
  localparam int SHIFT = 3*LOG2_DECIM + 1 - OUT_W;

  // Last phase of the decimation counter (D-1)
  localparam logic [LOG2_DECIM-1:0] DEC_LAST = {LOG2_DECIM{1'b1}};

  // Largest positive PCM code, in internal width for the compare and in output width
  localparam logic signed [W-1:0] POS_MAX_W = W'((1 << (OUT_W-1)) - 1);
  localparam logic [OUT_W-1:0]    POS_MAX_O = {1'b0, {(OUT_W-1){1'b1}}};

  // Number of strobes swallowed after reset while the comb delays fill
  localparam logic [1:0] WARM_DONE = 2'd3;

  // Map a stream bit to +1 / -1 in internal width
  function automatic logic [W-1:0] bit_to_step(input logic b);
    logic [W-1:0] v;
    if (b) begin
      v = {{(W-1){1'b0}}, 1'b1};
    end else begin
      v = {W{1'b1}};
    end
    return v;
  endfunction

  // Integrator chain
  logic [W-1:0] i1_r;
  logic [W-1:0] i2_r;
  logic [W-1:0] i3_r;

  // Comb delay registers (one decimated sample each)
  logic [W-1:0] d1_r;
  logic [W-1:0] d2_r;
  logic [W-1:0] d3_r;

  // Decimation phase and warm-up count
  logic [LOG2_DECIM-1:0] dec_cnt_r;
  logic [1:0]            warm_r;

  // Output registers
  logic [OUT_W-1:0] pcm_out_r;
  logic             pcm_valid_r;
  logic             pcm_sat_r;

  // Combinational datapath
  logic [W-1:0]          x_s;
  logic                  strobe_s;
  logic [W-1:0]          c1_s;
  logic [W-1:0]          c2_s;
  logic [W-1:0]          c3_s;
  logic signed [W-1:0]   y_s;
  logic                  over_s;
  logic [OUT_W-1:0]      pcm_next_s;

  // Input mapping and decimation strobe (last enabled bit of each frame)
  always_comb begin
    x_s      = bit_to_step(bit_in);
    strobe_s = 1'b0;
    if (bit_en && (dec_cnt_r == DEC_LAST)) begin
      strobe_s = 1'b1;
    end else begin
      strobe_s = 1'b0;
    end
  end

  // Comb section on the pre-edge integrator value, then scale down to PCM range
  always_comb begin
    c1_s = i3_r - d1_r;
    c2_s = c1_s - d2_r;
    c3_s = c2_s - d3_r;
    y_s  = $signed(c3_s) >>> SHIFT;
  end

  // Clip only the positive side: +full scale lands one code above +max
  always_comb begin
    over_s     = 1'b0;
    pcm_next_s = y_s[OUT_W-1:0];
    if (y_s > POS_MAX_W) begin
      over_s     = 1'b1;
      pcm_next_s = POS_MAX_O;
    end else begin
      over_s     = 1'b0;
      pcm_next_s = y_s[OUT_W-1:0];
    end
  end

  // Integrators advance only on enabled bits; each stage uses the old value of the previous one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_r <= {W{1'b0}};
      i2_r <= {W{1'b0}};
      i3_r <= {W{1'b0}};
    end else if (bit_en) begin
      i1_r <= i1_r + x_s;
      i2_r <= i2_r + i1_r;
      i3_r <= i3_r + i2_r;
    end else begin
      i1_r <= i1_r;
      i2_r <= i2_r;
      i3_r <= i3_r;
    end
  end

  // Decimation counter: 0..D-1 over enabled bits, frozen during gaps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_r <= {LOG2_DECIM{1'b0}};
    end else if (bit_en) begin
      if (dec_cnt_r == DEC_LAST) begin
        dec_cnt_r <= {LOG2_DECIM{1'b0}};
      end else begin
        dec_cnt_r <= dec_cnt_r + {{(LOG2_DECIM-1){1'b0}}, 1'b1};
      end
    end else begin
      dec_cnt_r <= dec_cnt_r;
    end
  end

  // Comb delays capture once per frame, including during warm-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_r <= {W{1'b0}};
      d2_r <= {W{1'b0}};
      d3_r <= {W{1'b0}};
    end else if (strobe_s) begin
      d1_r <= i3_r;
      d2_r <= c1_s;
      d3_r <= c2_s;
    end else begin
      d1_r <= d1_r;
      d2_r <= d2_r;
      d3_r <= d3_r;
    end
  end

  // Warm-up gate and output register: first three strobes are silent, later ones publish a sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_r      <= 2'd0;
      pcm_out_r   <= {OUT_W{1'b0}};
      pcm_sat_r   <= 1'b0;
      pcm_valid_r <= 1'b0;
    end else if (strobe_s) begin
      if (warm_r != WARM_DONE) begin
        warm_r      <= warm_r + 2'd1;
        pcm_out_r   <= pcm_out_r;
        pcm_sat_r   <= pcm_sat_r;
        pcm_valid_r <= 1'b0;
      end else begin
        warm_r      <= warm_r;
        pcm_out_r   <= pcm_next_s;
        pcm_sat_r   <= over_s;
        pcm_valid_r <= 1'b1;
      end
    end else begin
      warm_r      <= warm_r;
      pcm_out_r   <= pcm_out_r;
      pcm_sat_r   <= pcm_sat_r;
      pcm_valid_r <= 1'b0;
    end
  end

  assign pcm_out   = pcm_out_r;
  assign pcm_valid = pcm_valid_r;
  assign pcm_sat   = pcm_sat_r;

endmodule

// File: tb/tb_sd_cic_decim.sv
// Self-checking bench for sd_cic_decim.
// Reference: a sinc3 output is the input sequence convolved with the cascade of three
// length-D boxcars; the model keeps the whole enabled-bit history and evaluates that
// convolution at every decimation point, then applies scaling, clipping and warm-up.
module tb_sd_cic_decim;

  localparam int    LOG2_DECIM = 6;
  localparam int    OUT_W      = 16;
  localparam int    D          = 1 << LOG2_DECIM;
  localparam int    SHIFT      = 3*LOG2_DECIM + 1 - OUT_W;
  localparam int    PCM_MAX    = (1 << (OUT_W-1)) - 1;
  localparam real   AMP        = 10000.0;
  localparam real   PERIOD     = 8192.0;
  localparam real   TWO_PI     = 6.283185307179586;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bit_in;
  logic             bit_en;
  logic [OUT_W-1:0] pcm_out;
  logic             pcm_valid;
  logic             pcm_sat;

  sd_cic_decim #(.LOG2_DECIM(LOG2_DECIM), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_in   (bit_in),
    .bit_en   (bit_en),
    .pcm_out  (pcm_out),
    .pcm_valid(pcm_valid),
    .pcm_sat  (pcm_sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int   x_hist[$];
  int   ph_hist[$];
  int   strobes;
  int   emits;
  logic exp_valid;
  logic exp_sat;
  int   exp_out;
  int   hker[3*D];
  real  centroid;

  // Second-order sigma-delta source state
  real  s1, s2;
  int   ph;

  function automatic int tri2(input int a);
    return (a >= 2) ? (a * (a - 1)) / 2 : 0;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b expected %0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    n_cmp++;
    assert ((obs - exp <= tol) && (exp - obs <= tol)) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d +/- %0d at %0t", tag, obs, exp, tol, $time);
    end
  endtask

  task automatic model_clear();
    x_hist.delete();
    ph_hist.delete();
    strobes   = 0;
    emits     = 0;
    exp_valid = 1'b0;
    exp_sat   = 1'b0;
    exp_out   = 0;
  endtask

  // One clock edge of the reference with reset released
  task automatic model_edge(input logic b, input logic e);
    int n, c3, y;
    exp_valid = 1'b0;
    if (e) begin
      x_hist.push_back(b ? 1 : -1);
      ph_hist.push_back(ph);
      n = x_hist.size() - 1;
      if ((n % D) == D - 1) begin
        strobes++;
        if (strobes > 3) begin
          c3 = 0;
          for (int j = 0; j < 3*D; j++) begin
            if (n - 1 - j >= 0) c3 += hker[j] * x_hist[n-1-j];
          end
          y = c3 >>> SHIFT;
          exp_valid = 1'b1;
          emits++;
          if (y > PCM_MAX) begin
            exp_out = PCM_MAX;
            exp_sat = 1'b1;
          end else begin
            exp_out = y;
            exp_sat = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_bit("pcm_valid", pcm_valid, exp_valid);
    check_int("pcm_out", int'($signed(pcm_out)), exp_out);
    check_bit("pcm_sat", pcm_sat, exp_sat);
  endtask

  // Drive one cycle, let the edge happen, then compare away from it
  task automatic step(input logic b, input logic e);
    bit_in = b;
    bit_en = e;
    @(posedge clk);
    #1;
    if (rst_n) model_edge(b, e);
    check_outputs();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs();
    for (int k = 0; k < 4; k++) step(1'($urandom_range(0, 1)), 1'b1);
    rst_n = 1'b1;
  endtask

  // Next bit of a second-order modulator fed with a 10000-LSB sine
  task automatic mod_bit(output logic b);
    real u, y, s1_old;
    u = (AMP / 32768.0) * $sin(TWO_PI * real'(ph) / PERIOD);
    b = (s2 >= 0.0);
    y = b ? 1.0 : -1.0;
    s1_old = s1;
    s1 = s1 + 0.5 * (u - y);
    s2 = s2 + 0.5 * (s1_old - y);
    ph++;
  endtask

  // Feed the modulated sine; check sample values against the ideal sine at the kernel centre
  task automatic sine_run(input int count);
    logic b;
    real  t;
    int   ideal;
    for (int k = 0; k < count; k++) begin
      mod_bit(b);
      step(b, 1'b1);
      if (exp_valid && emits >= 2) begin
        // modulator delays its input by two samples
        t = real'(ph_hist[x_hist.size()-1]) - 1.0 - centroid - 2.0;
        ideal = int'(AMP * $sin(TWO_PI * t / PERIOD));
        check_near("sine_track", int'($signed(pcm_out)), ideal, 64);
      end
    end
  endtask

  initial begin
    int first, pulses, last, k, pat;
    logic b;
    real hs, hm;

    // sinc3 kernel with the integrator pipeline offset, and its centroid
    hs = 0.0;
    hm = 0.0;
    for (int j = 0; j < 3*D; j++) begin
      hker[j] = tri2(j) - 3*tri2(j-D) + 3*tri2(j-2*D) - tri2(j-3*D);
      hs += real'(hker[j]);
      hm += real'(j) * real'(hker[j]);
    end
    centroid = hm / hs;
    s1 = 0.0;
    s2 = 0.0;
    ph = 0;

    // 1: reset with activity, then idle with bit_en low
    bit_in = 1'b0;
    bit_en = 1'b1;
    apply_reset();
    for (int i = 0; i < 500; i++) step(1'($urandom_range(0, 1)), 1'b0);
    check_bit("idle_no_pulse", pcm_valid, 1'b0);

    // 2: constant ones -> first pulse on strobe 4, then saturated +max
    first  = 0;
    pulses = 0;
    for (int i = 1; i <= 10*D; i++) begin
      step(1'b1, 1'b1);
      if (pcm_valid) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    check_int("ones_first_pulse", first, 4*D);
    check_int("ones_pulses", pulses, 7);
    check_int("ones_value", int'($signed(pcm_out)), 32767);
    check_bit("ones_sat", pcm_sat, 1'b1);

    // 3: constant zeros -> -full scale, not flagged
    apply_reset();
    for (int i = 0; i < 10*D; i++) step(1'b0, 1'b1);
    check_int("zeros_value", int'($signed(pcm_out)), -32768);
    check_bit("zeros_sat", pcm_sat, 1'b0);

    // 4: 1010 settles to 0, 1110 settles to +half scale
    apply_reset();
    for (int i = 0; i < 10*D; i++) step(1'(i % 2 == 0), 1'b1);
    check_int("alt_value", int'($signed(pcm_out)), 0);
    for (int i = 0; i < 10*D; i++) step(1'(i % 4 != 3), 1'b1);
    check_int("1110_value", int'($signed(pcm_out)), 16384);
    check_bit("1110_sat", pcm_sat, 1'b0);

    // 5: 1110 with bit_en every other clock; bit_in is noise in the gaps
    pulses = 0;
    last   = 0;
    pat    = 0;
    for (int i = 1; i <= 20*D; i++) begin
      if (i % 2 == 1) begin
        step(1'(pat % 4 != 3), 1'b1);
        pat++;
      end else begin
        step(1'($urandom_range(0, 1)), 1'b0);
      end
      if (pcm_valid) begin
        pulses++;
        if (last != 0) check_int("gap_spacing", i - last, 2*D);
        last = i;
      end
    end
    check_int("gap_pulses", pulses, 10);
    check_int("gap_value", int'($signed(pcm_out)), 16384);

    // 6: sine from a sigma-delta source, asynchronous reset mid-frame, then resume
    apply_reset();
    sine_run(12000 + int'($urandom_range(1, 30)));
    #3;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_outputs();
    for (int i = 0; i < 3; i++) begin
      mod_bit(b);
      step(b, 1'b1);
    end
    rst_n = 1'b1;
    first = 0;
    k     = 0;
    while (k < 8192) begin
      sine_run(1);
      k++;
      if (pcm_valid && first == 0) first = k;
    end
    check_int("post_reset_first_pulse", first, 4*D);

    // 7: random bits with random enable gaps
    apply_reset();
    for (int i = 0; i < 4000; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
